// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : Instruction-fetch stage of an in-order pipeline. Holds the PC,
//            presents it to instruction memory and captures the returned word
//            into the IF/ID pipeline register. It supports hazard stalls and
//            redirects from downstream branch/jump resolution.
// Ports    : clk_i, rst_i (sync, active-high)
//            stall_i                  - freeze PC and IF/ID
//            redirect_i/redirect_pc_i - load new PC, flush IF/ID to a bubble
//            imem_addr_o/imem_instr_i - instruction memory (combinational read)
//            if_id_pc_plus4_o, if_id_instr_o, if_id_valid_o - IF/ID register
//            fetch_cnt_o, stall_cnt_o - performance counters (optional)
// Config   : define FETCH_PERF_CNT_EN to add the performance counters
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_instr_i,
    output logic [31:0] if_id_pc_plus4_o,
    output logic [31:0] if_id_instr_o,
    output logic        if_id_valid_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] stall_cnt_o
`endif
);

    logic [31:0] r_pc;
    logic [31:0] r_pc_plus4;
    logic [31:0] r_instr;
    logic        r_valid;
    logic [31:0] w_pc_plus4;

    // Unsigned add wraps naturally modulo 2^32.
    assign w_pc_plus4 = r_pc + 32'd4;

    // Redirect outranks stall: the redirecting instruction is older than the
    // stalled one, so whatever sits in IF/ID is on the wrong path anyway.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pc       <= {RESET_PC[31:2], 2'b00};
            r_pc_plus4 <= 32'h0000_0000;
            r_instr    <= NOP_INSTR;
            r_valid    <= 1'b0;
        end else if (redirect_i) begin
            r_pc       <= {redirect_pc_i[31:2], 2'b00};
            r_pc_plus4 <= 32'h0000_0000;
            r_instr    <= NOP_INSTR;
            r_valid    <= 1'b0;
        end else if (!stall_i) begin
            r_pc       <= w_pc_plus4;
            r_pc_plus4 <= w_pc_plus4;
            r_instr    <= imem_instr_i;
            r_valid    <= 1'b1;
        end
    end

    // PC goes straight to memory: no input reaches imem_addr_o combinationally.
    assign imem_addr_o      = r_pc;
    assign if_id_pc_plus4_o = r_pc_plus4;
    assign if_id_instr_o    = r_instr;
    assign if_id_valid_o    = r_valid;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_fetch_cnt <= 32'h0000_0000;
            r_stall_cnt <= 32'h0000_0000;
        end else if (!redirect_i) begin
            if (stall_i) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end else begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
        end
    end

    assign fetch_cnt_o = r_fetch_cnt;
    assign stall_cnt_o = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Self-checking bench for fetch_stage. Applies a table of directed
//            vectors (reset, advance, stall, redirect, reset-over-stall) and
//            compares IF/ID and PC each cycle; a second instance with
//            RESET_PC at the top of memory covers PC wrap-around. The
//            counter check runs only when FETCH_PERF_CNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] c_NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;

    logic [31:0] w_addr,  w_instr,  w_p4,  w_ins;
    logic        w_valid;
    logic [31:0] w_addr2, w_instr2, w_p42, w_ins2;
    logic        w_valid2;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] w_fcnt, w_scnt, w_fcnt2, w_scnt2;
`endif

    // Instruction memory model: word at byte address A is A/4.
    assign w_instr  = w_addr  >> 2;
    assign w_instr2 = w_addr2 >> 2;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(c_NOP)) dut (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .redirect_i(redirect),
        .redirect_pc_i(redirect_pc), .imem_addr_o(w_addr),
        .imem_instr_i(w_instr), .if_id_pc_plus4_o(w_p4),
        .if_id_instr_o(w_ins), .if_id_valid_o(w_valid)
`ifdef FETCH_PERF_CNT_EN
        , .fetch_cnt_o(w_fcnt), .stall_cnt_o(w_scnt)
`endif
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(c_NOP)) dut_wrap (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .redirect_i(redirect),
        .redirect_pc_i(redirect_pc), .imem_addr_o(w_addr2),
        .imem_instr_i(w_instr2), .if_id_pc_plus4_o(w_p42),
        .if_id_instr_o(w_ins2), .if_id_valid_o(w_valid2)
`ifdef FETCH_PERF_CNT_EN
        , .fetch_cnt_o(w_fcnt2), .stall_cnt_o(w_scnt2)
`endif
    );

    typedef struct {
        logic        rst;
        logic        stall;
        logic        redirect;
        logic [31:0] rpc;
        logic [31:0] pc;
        logic [31:0] p4;
        logic [31:0] ins;
        logic        valid;
        logic [31:0] pc2;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic add(input logic r, input logic s, input logic d,
                       input logic [31:0] rpc, input logic [31:0] pc,
                       input logic [31:0] p4, input logic [31:0] ins,
                       input logic v, input logic [31:0] pc2);
        vec_t t;
        t.rst = r; t.stall = s; t.redirect = d; t.rpc = rpc;
        t.pc = pc; t.p4 = p4; t.ins = ins; t.valid = v; t.pc2 = pc2;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s vec=%0d actual=%h expected=%h", name, idx, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic d,
                        input logic [31:0] rpc);
        rst = r; stall = s; redirect = d; redirect_pc = rpc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;

        //   rst stall redir rpc        pc           p4        ins       v   pc2
        add(1, 0, 0, 32'h0,  32'h00, 32'h00, c_NOP,  0, 32'hFFFF_FFFC); // 0 reset
        add(1, 0, 0, 32'h0,  32'h00, 32'h00, c_NOP,  0, 32'hFFFF_FFFC); // 1 reset
        add(0, 0, 0, 32'h0,  32'h04, 32'h04, 32'h0,  1, 32'h0000_0000); // 2 wrap in dut_wrap
        add(0, 0, 0, 32'h0,  32'h08, 32'h08, 32'h1,  1, 32'h0000_0004); // 3
        add(0, 1, 0, 32'h0,  32'h08, 32'h08, 32'h1,  1, 32'h0000_0004); // 4 stall
        add(0, 1, 0, 32'h0,  32'h08, 32'h08, 32'h1,  1, 32'h0000_0004); // 5 stall
        add(0, 1, 0, 32'h0,  32'h08, 32'h08, 32'h1,  1, 32'h0000_0004); // 6 stall
        add(0, 0, 0, 32'h0,  32'h0C, 32'h0C, 32'h2,  1, 32'h0000_0008); // 7 release
        add(0, 0, 0, 32'h0,  32'h10, 32'h10, 32'h3,  1, 32'h0000_000C); // 8
        add(0, 1, 1, 32'h40, 32'h40, 32'h00, c_NOP,  0, 32'h0000_0040); // 9 redirect+stall
        add(0, 0, 0, 32'h0,  32'h44, 32'h44, 32'h10, 1, 32'h0000_0044); // 10 target arrives
        add(0, 0, 1, 32'h43, 32'h40, 32'h00, c_NOP,  0, 32'h0000_0040); // 11 unaligned target
        add(0, 0, 1, 32'h80, 32'h80, 32'h00, c_NOP,  0, 32'h0000_0080); // 12 back-to-back
        add(0, 0, 0, 32'h0,  32'h84, 32'h84, 32'h20, 1, 32'h0000_0084); // 13
        add(0, 0, 0, 32'h0,  32'h88, 32'h88, 32'h21, 1, 32'h0000_0088); // 14
        add(0, 0, 1, 32'h14, 32'h14, 32'h00, c_NOP,  0, 32'h0000_0014); // 15 go to PC=20
        add(0, 1, 0, 32'h0,  32'h14, 32'h00, c_NOP,  0, 32'h0000_0014); // 16 stall
        add(1, 1, 0, 32'h0,  32'h00, 32'h00, c_NOP,  0, 32'hFFFF_FFFC); // 17 reset in stall
        add(0, 0, 0, 32'h0,  32'h04, 32'h04, 32'h0,  1, 32'h0000_0000); // 18

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].stall, vecs[i].redirect, vecs[i].rpc);
            check("imem_addr",    i, w_addr,  vecs[i].pc);
            check("pc_plus4",     i, w_p4,    vecs[i].p4);
            check("instr",        i, w_ins,   vecs[i].ins);
            check("valid",        i, {31'b0, w_valid}, {31'b0, vecs[i].valid});
            check("wrap_addr",    i, w_addr2, vecs[i].pc2);
        end

        // Reset while a redirect is presented: reset wins.
        step(1, 0, 1, 32'h100);
        check("rst_over_redirect_pc",    100, w_addr, 32'h0);
        check("rst_over_redirect_valid", 100, {31'b0, w_valid}, 32'h0);

`ifdef FETCH_PERF_CNT_EN
        step(1, 0, 0, 32'h0);
        check("fetch_cnt_reset", 200, w_fcnt, 32'd0);
        check("stall_cnt_reset", 200, w_scnt, 32'd0);
        for (int k = 0; k < 2; k++) step(0, 0, 0, 32'h0);
        for (int k = 0; k < 3; k++) step(0, 1, 0, 32'h0);
        step(0, 1, 1, 32'h40);  // redirect with stall: counts as neither
        for (int k = 0; k < 3; k++) step(0, 0, 0, 32'h0);
        check("fetch_cnt", 201, w_fcnt, 32'd5);
        check("stall_cnt", 201, w_scnt, 32'd3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
